// File: rtl/load_store_unit_if.sv
// Core request/response and word-memory signals of the load/store unit.
// master = core/memory environment side, slave = the load/store unit.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_option;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output req_valid, req_write, req_funct3, req_address, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_read, mem_write, mem_option, mem_address, mem_wdata
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_address, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_read, mem_write, mem_option, mem_address, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RISC-V style load/store unit over a word-only memory; sub-word stores use read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses instead of aligning them down.
module load_store_unit (
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state, state_nxt;
    logic        write_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic        error_q;

    logic        accept;
    logic        f3_legal;
    logic        misaligned;
    logic        acc_error;
    logic [31:0] acc_address;

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wd,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  lane);
        logic [31:0] r;
        r = word;
        case (f3[1:0])
            2'b00: begin
                case (lane)
                    2'd0:    r[7:0]   = wd[7:0];
                    2'd1:    r[15:8]  = wd[7:0];
                    2'd2:    r[23:16] = wd[7:0];
                    default: r[31:24] = wd[7:0];
                endcase
            end
            2'b01: begin
                if (lane[1]) r[31:16] = wd[15:0];
                else         r[15:0]  = wd[15:0];
            end
            default: r = wd;
        endcase
        return r;
    endfunction

    assign accept = bus.req_valid && (state == IDLE);

    always_comb begin
        f3_legal = 1'b0;
        case (bus.req_funct3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = !bus.req_write;
            default:                f3_legal = 1'b0;
        endcase
        misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_address[0]) ||
                     ((bus.req_funct3[1:0] == 2'b10) && (bus.req_address[1:0] != 2'b00));
`ifdef LSU_MISALIGN_TRAP_EN
        acc_error   = !f3_legal || misaligned;
        acc_address = bus.req_address;
`else
        acc_error   = !f3_legal;
        acc_address = bus.req_address;
        // Misaligned accesses are forced down to natural alignment.
        if (bus.req_funct3[1:0] == 2'b01)
            acc_address[0] = 1'b0;
        else if (bus.req_funct3[1:0] == 2'b10)
            acc_address[1:0] = 2'b00;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_q  <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            word_q   <= 32'd0;
            error_q  <= 1'b0;
        end else begin
            if (accept) begin
                write_q  <= bus.req_write;
                funct3_q <= bus.req_funct3;
                addr_q   <= acc_address;
                wdata_q  <= bus.req_wdata;
                error_q  <= acc_error;
            end
            if (state == READ)
                word_q <= bus.mem_rdata;
        end
    end

    always_comb begin
        state_nxt       = state;
        bus.req_ready   = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_wdata   = 32'd0;
        bus.resp_valid  = 1'b0;
        bus.resp_error  = 1'b0;
        bus.resp_rdata  = 32'd0;
        bus.mem_option  = 3'b010;
        bus.mem_address = {addr_q[31:2], 2'b00};
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (accept) begin
                    if (acc_error)
                        state_nxt = RESP;
                    else if (bus.req_write && (bus.req_funct3[1:0] == 2'b10))
                        state_nxt = WRITE;
                    else
                        state_nxt = READ;
                end
            end
            READ: begin
                bus.mem_read = 1'b1;
                state_nxt    = write_q ? WRITE : RESP;
            end
            WRITE: begin
                bus.mem_write = 1'b1;
                bus.mem_wdata = store_merge(word_q, wdata_q, funct3_q, addr_q[1:0]);
                state_nxt     = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_error = error_q;
                if (!write_q && !error_q)
                    bus.resp_rdata = load_extract(word_q, funct3_q, addr_q[1:0]);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
